// File: rtl/cmd_pkg.sv
// Shared types for the command registry: record layout, staging word map and FSM states.
package cmd_pkg;

  // One burst command as loaded onto the sequencer MEM_* bus.
  typedef struct packed {
    logic [47:0] freq;
    logic [47:0] delta_freq;
    logic [31:0] delta_rate;
    logic [63:0] time_start;
    logic [1:0]  type_impulse;
    logic [15:0] n_impuls;
    logic [31:0] interval_ti;
    logic [31:0] interval_tp;
    logic [31:0] tblank1;
    logic [31:0] tblank2;
  } cmd_t;

  // Host staging word indices.
  localparam logic [3:0] W_FREQ_LO   = 4'd0;
  localparam logic [3:0] W_FREQ_HI   = 4'd1;
  localparam logic [3:0] W_DFREQ_LO  = 4'd2;
  localparam logic [3:0] W_DFREQ_HI  = 4'd3;
  localparam logic [3:0] W_DRATE     = 4'd4;
  localparam logic [3:0] W_TSTART_LO = 4'd5;
  localparam logic [3:0] W_TSTART_HI = 4'd6;
  localparam logic [3:0] W_NTYPE     = 4'd7;
  localparam logic [3:0] W_TI        = 4'd8;
  localparam logic [3:0] W_TP        = 4'd9;
  localparam logic [3:0] W_TBLANK1   = 4'd10;
  localparam logic [3:0] W_TBLANK2   = 4'd11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    CHECK = 2'd2,
    ISSUE = 2'd3
  } state_t;

endpackage

// File: rtl/cmd_ram.sv
// Simple dual-port command store: one write port, one registered read port (1-cycle latency).
// Ports: CLK; wr_en/wr_addr/wr_data write side; rd_en/rd_addr request a read, rd_data valid next cycle.
module cmd_ram
  import cmd_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          CLK,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  cmd_t          wr_data,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output cmd_t          rd_data
);

  cmd_t mem [DEPTH];

  // Read-before-write on a same-address collision: the reader sees the old entry.
  always_ff @(posedge CLK) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/cmd_registry.sv
// Command registry: host staging + FIFO of burst commands, presenting one command at a time
// to the pulse-burst sequencer and dropping commands whose start time is too close or past.
// Ports: CLK/RESET (sync, active-high); TIME current time; HOST_WR/HOST_ADDR/HOST_DATA staging
// writes; HOST_COMMIT push; CLR_STATUS clears OVERFLOW/LATE_CNT; REQ_COMMAND rising edge frees the
// presented slot; WR_DATA load strobe with MEM_* record; COUNT/FULL/EMPTY/OVERFLOW/LATE_CNT status.
module cmd_registry
  import cmd_pkg::*;
#(
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned LATE_MARGIN = 48
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic [63:0]            TIME,
  input  logic                   HOST_WR,
  input  logic [3:0]             HOST_ADDR,
  input  logic [31:0]            HOST_DATA,
  input  logic                   HOST_COMMIT,
  input  logic                   CLR_STATUS,
  input  logic                   REQ_COMMAND,
  output logic                   WR_DATA,
  output logic [47:0]            MEM_DDS_freq,
  output logic [47:0]            MEM_DDS_delta_freq,
  output logic [31:0]            MEM_DDS_delta_rate,
  output logic [31:0]            MEM_Interval_Ti,
  output logic [31:0]            MEM_Interval_Tp,
  output logic [31:0]            MEM_Tblank1,
  output logic [31:0]            MEM_Tblank2,
  output logic [63:0]            MEM_TIME_START,
  output logic [15:0]            MEM_N_impuls,
  output logic [1:0]             MEM_TYPE_impulse,
  output logic [$clog2(DEPTH):0] COUNT,
  output logic                   FULL,
  output logic                   EMPTY,
  output logic                   OVERFLOW,
  output logic [7:0]             LATE_CNT
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  cmd_t          stg;
  cmd_t          rd_cmd;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          slot_valid;
  logic          req_q;
  state_t        state;
  state_t        state_nxt;

  logic          pop_c;
  logic          issue_c;
  logic          drop_c;
  logic          push_c;
  logic          req_rise_c;
  logic          stale_c;
  logic [63:0]   lead_c;
  logic [CW-1:0] count_nxt_c;

  // Staging words; narrow fields keep only their low bits.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      stg <= '0;
    end else if (HOST_WR) begin
      case (HOST_ADDR)
        W_FREQ_LO:   stg.freq[31:0]       <= HOST_DATA;
        W_FREQ_HI:   stg.freq[47:32]      <= HOST_DATA[15:0];
        W_DFREQ_LO:  stg.delta_freq[31:0] <= HOST_DATA;
        W_DFREQ_HI:  stg.delta_freq[47:32] <= HOST_DATA[15:0];
        W_DRATE:     stg.delta_rate       <= HOST_DATA;
        W_TSTART_LO: stg.time_start[31:0] <= HOST_DATA;
        W_TSTART_HI: stg.time_start[63:32] <= HOST_DATA;
        W_NTYPE: begin
          stg.type_impulse <= HOST_DATA[17:16];
          stg.n_impuls     <= HOST_DATA[15:0];
        end
        W_TI:        stg.interval_ti <= HOST_DATA;
        W_TP:        stg.interval_tp <= HOST_DATA;
        W_TBLANK1:   stg.tblank1     <= HOST_DATA;
        W_TBLANK2:   stg.tblank2     <= HOST_DATA;
        default: ;
      endcase
    end
  end

  // A push while full is accepted only if a pop frees the same entry this cycle.
  assign push_c      = HOST_COMMIT && (!FULL || pop_c);
  assign count_nxt_c = COUNT + CW'(push_c) - CW'(pop_c);

  // FIFO pointers and occupancy.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      COUNT  <= '0;
      EMPTY  <= 1'b1;
      FULL   <= 1'b0;
    end else begin
      if (push_c) wr_ptr <= wr_ptr + AW'(1);
      if (pop_c)  rd_ptr <= rd_ptr + AW'(1);
      COUNT <= count_nxt_c;
      EMPTY <= (count_nxt_c == '0);
      FULL  <= (count_nxt_c == CW'(DEPTH));
    end
  end

  cmd_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .CLK     (CLK),
    .wr_en   (push_c),
    .wr_addr (wr_ptr),
    .wr_data (stg),
    .rd_en   (pop_c),
    .rd_addr (rd_ptr),
    .rd_data (rd_cmd)
  );

  // Stale test is a plain modulo-2^64 compare; no wrap handling.
  assign lead_c     = TIME + 64'(LATE_MARGIN);
  assign stale_c    = rd_cmd.time_start < lead_c;
  assign req_rise_c = REQ_COMMAND && !req_q;

  // Presented-slot ownership.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      req_q      <= 1'b0;
      slot_valid <= 1'b0;
    end else begin
      req_q <= REQ_COMMAND;
      if (issue_c)         slot_valid <= 1'b1;
      else if (req_rise_c) slot_valid <= 1'b0;
    end
  end

  // FSM state register.
  always_ff @(posedge CLK) begin
    if (RESET) state <= IDLE;
    else       state <= state_nxt;
  end

  // FSM next state and control strobes.
  always_comb begin
    state_nxt = state;
    pop_c     = 1'b0;
    issue_c   = 1'b0;
    drop_c    = 1'b0;
    case (state)
      IDLE: begin
        if (!slot_valid && !EMPTY) state_nxt = FETCH;
      end
      FETCH: begin
        pop_c     = 1'b1;
        state_nxt = CHECK;
      end
      CHECK: begin
        if (stale_c) begin
          drop_c    = 1'b1;
          state_nxt = EMPTY ? IDLE : FETCH;
        end else begin
          issue_c   = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Load bus: registered at the CHECK decision, so the strobe is visible in ISSUE.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      WR_DATA            <= 1'b0;
      MEM_DDS_freq       <= '0;
      MEM_DDS_delta_freq <= '0;
      MEM_DDS_delta_rate <= '0;
      MEM_Interval_Ti    <= '0;
      MEM_Interval_Tp    <= '0;
      MEM_Tblank1        <= '0;
      MEM_Tblank2        <= '0;
      MEM_TIME_START     <= '0;
      MEM_N_impuls       <= '0;
      MEM_TYPE_impulse   <= '0;
    end else begin
      WR_DATA <= issue_c;
      if (issue_c) begin
        MEM_DDS_freq       <= rd_cmd.freq;
        MEM_DDS_delta_freq <= rd_cmd.delta_freq;
        MEM_DDS_delta_rate <= rd_cmd.delta_rate;
        MEM_Interval_Ti    <= rd_cmd.interval_ti;
        MEM_Interval_Tp    <= rd_cmd.interval_tp;
        MEM_Tblank1        <= rd_cmd.tblank1;
        MEM_Tblank2        <= rd_cmd.tblank2;
        MEM_TIME_START     <= rd_cmd.time_start;
        MEM_N_impuls       <= rd_cmd.n_impuls;
        MEM_TYPE_impulse   <= rd_cmd.type_impulse;
      end
    end
  end

  // Sticky status; a clear beats a same-cycle event.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      OVERFLOW <= 1'b0;
      LATE_CNT <= '0;
    end else if (CLR_STATUS) begin
      OVERFLOW <= 1'b0;
      LATE_CNT <= '0;
    end else begin
      if (HOST_COMMIT && FULL && !pop_c) OVERFLOW <= 1'b1;
      if (drop_c && (LATE_CNT != 8'hFF)) LATE_CNT <= LATE_CNT + 8'd1;
    end
  end

endmodule
